// File: rtl/memory_game_display_core_pkg.sv
// Shared types, constants and the hex-to-segment decoder for the memory game display.
package memory_game_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] anode_t;

  typedef struct packed {
    anode_t anode;
    seg_t   seg;
  } disp_t;

  localparam anode_t ANODES_OFF = 4'b1111;
  localparam seg_t   SEG_OFF    = 7'b1111111;

  // Segment order {a,b,c,d,e,f,g}, active-low.
  localparam seg_t SEG_0 = 7'b0000001;
  localparam seg_t SEG_1 = 7'b1001111;
  localparam seg_t SEG_2 = 7'b0010010;
  localparam seg_t SEG_3 = 7'b0000110;
  localparam seg_t SEG_4 = 7'b1001100;
  localparam seg_t SEG_5 = 7'b0100100;
  localparam seg_t SEG_6 = 7'b0100000;
  localparam seg_t SEG_7 = 7'b0001111;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0000100;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b1100000;
  localparam seg_t SEG_C = 7'b0110001;
  localparam seg_t SEG_D = 7'b1000010;
  localparam seg_t SEG_E = 7'b0110000;
  localparam seg_t SEG_F = 7'b0111000;

  // Tick generator slots
  localparam int NUM_TICKS = 3;
  localparam int TK_FAST   = 0;
  localparam int TK_BLINK  = 1;
  localparam int TK_READ   = 2;

  function automatic seg_t hexToSeg(input logic [3:0] nib);
    seg_t s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction
endpackage

// File: rtl/memory_game_display_core_if.sv
// Game-logic <-> display-core signal bundle; master is the game side, slave is the core.
interface memory_game_display_core_if;
  import memory_game_pkg::*;

  logic        displayPhase;
  logic [15:0] randInt;
  logic [15:0] userInput;
  logic        inputReady;
  logic        correct;
  logic        fastTick;
  logic        blinkOn;
  logic        readTick;
  anode_t      anodeActivate;
  seg_t        LED_out;

  modport master (
    output displayPhase, randInt, userInput, inputReady,
    input  correct, fastTick, blinkOn, readTick, anodeActivate, LED_out
  );

  modport slave (
    input  displayPhase, randInt, userInput, inputReady,
    output correct, fastTick, blinkOn, readTick, anodeActivate, LED_out
  );
endinterface

// File: rtl/memory_game_display_core_tick_gen.sv
// Free-running divider: tick is high for the single cycle where the count sits at DIV-1.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/memory_game_display_core.sv
// Timing enables, answer compare and 4-digit multiplexed seven-segment drive.
module memory_game_display_core
  import memory_game_pkg::*;
#(
  parameter int FAST_DIV  = 100_000,
  parameter int BLINK_DIV = 25_000_000,
  parameter int READ_DIV  = 5_000_000
) (
  input logic                         clk,
  input logic                         rst,
  memory_game_display_core_if.slave   bus
);
  localparam int DIVS [NUM_TICKS] = '{FAST_DIV, BLINK_DIV, READ_DIV};

  logic [NUM_TICKS-1:0] ticks;
  logic                 blinkOn;
  logic [1:0]           idx;
  logic                 correct;
  logic                 blank;
  logic [15:0]          selVal;
  logic [3:0]           nib;
  disp_t                dispD, dispQ;

  for (genvar g = 0; g < NUM_TICKS; g++) begin : gTick
    tick_gen #(.DIV(DIVS[g])) uTick (
      .clk  (clk),
      .rst  (rst),
      .tick (ticks[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)                  blinkOn <= 1'b1;
    else if (ticks[TK_BLINK]) blinkOn <= ~blinkOn;
  end

  always_ff @(posedge clk) begin
    if (rst)                 idx <= 2'd0;
    else if (ticks[TK_FAST]) idx <= idx + 2'd1;
  end

  assign correct = (bus.userInput == bus.randInt);
  assign selVal  = bus.displayPhase ? bus.randInt : bus.userInput;
  assign nib     = selVal[{idx, 2'b00} +: 4];

  // A wrong, completed entry flashes: dark during the off half of the blink period.
  assign blank = ~bus.displayPhase & bus.inputReady & ~correct & ~blinkOn;

  always_comb begin
    dispD.anode = ~(4'b0001 << idx);
    dispD.seg   = hexToSeg(nib);
    if (blank) dispD.anode = ANODES_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dispQ.anode <= ANODES_OFF;
      dispQ.seg   <= SEG_OFF;
    end else begin
      dispQ <= dispD;
    end
  end

  assign bus.correct       = correct;
  assign bus.fastTick      = ticks[TK_FAST];
  assign bus.blinkOn       = blinkOn;
  assign bus.readTick      = ticks[TK_READ];
  assign bus.anodeActivate = dispQ.anode;
  assign bus.LED_out       = dispQ.seg;
endmodule

// File: tb/tb_memory_game_display_core.sv
// Directed and random stimulus checked against a cycle-count arithmetic model of the display core.
module tb_memory_game_display_core;
  localparam int FD = 4, BD = 16, RD = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_game_display_core_if bus();

  memory_game_display_core #(.FAST_DIV(FD), .BLINK_DIV(BD), .READ_DIV(RD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] segTab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int checks = 0;
  int passes = 0;
  int n = 0;  // clock cycles elapsed since the last reset edge

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, n, obs, exp);
  endtask

  // One clock: check correct on the settled inputs, then the registered outputs after the edge.
  task automatic step();
    logic        sDp, sRdy, sRst, bl, blank;
    logic [15:0] sR, sU, v;
    logic [3:0]  an;
    int          sN, idx;
    #1;
    chk("correct", {15'd0, bus.correct}, {15'd0, bus.userInput == bus.randInt});
    sDp = bus.displayPhase; sRdy = bus.inputReady; sRst = rst;
    sR = bus.randInt; sU = bus.userInput; sN = n;
    @(posedge clk);
    #1;
    if (sRst) begin
      n = 0;
      chk("rstAnode", {12'd0, bus.anodeActivate}, 16'h000f);
      chk("rstLed", {9'd0, bus.LED_out}, 16'h007f);
    end else begin
      n     = sN + 1;
      idx   = (sN / FD) % 4;
      bl    = ((sN / BD) % 2) == 0;
      v     = sDp ? sR : sU;
      blank = !sDp && sRdy && (sU != sR) && !bl;
      an    = 4'hf;
      if (!blank) an[idx] = 1'b0;
      chk("anode", {12'd0, bus.anodeActivate}, {12'd0, an});
      if (!blank) chk("led", {9'd0, bus.LED_out}, {9'd0, segTab[v[4*idx +: 4]]});
    end
    chk("fastTick", {15'd0, bus.fastTick}, {15'd0, (n % FD) == FD - 1});
    chk("readTick", {15'd0, bus.readTick}, {15'd0, (n % RD) == RD - 1});
    chk("blinkOn", {15'd0, bus.blinkOn}, {15'd0, ((n / BD) % 2) == 0});
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    bus.displayPhase = 1'b0;
    bus.randInt      = 16'h0000;
    bus.userInput    = 16'h0000;
    bus.inputReady   = 1'b0;
    step(); step();
    rst = 1'b0;

    bus.displayPhase = 1'b1; bus.randInt = 16'h1234;
    repeat (16) step();

    bus.displayPhase = 1'b0; bus.userInput = 16'hABCD; bus.inputReady = 1'b0;
    repeat (16) step();

    bus.userInput = 16'h5A5A; bus.randInt = 16'h5A5A; bus.inputReady = 1'b1;
    repeat (64) step();

    bus.userInput = 16'h0001; bus.randInt = 16'h0002;
    repeat (64) step();

    // Reset while digit 2 is being refreshed; digit 0 must come back first.
    bus.displayPhase = 1'b1; bus.randInt = 16'h9E7C;
    guard = 0;
    while (((n / FD) % 4) != 2 && guard < 32) begin
      step();
      guard++;
    end
    chk("idx2Reached", {15'd0, ((n / FD) % 4) == 2}, 16'd1);
    rst = 1'b1; step();
    rst = 1'b0; repeat (12) step();

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 7) == 0) begin
        bus.displayPhase = ($urandom_range(0, 3) == 0);
        bus.inputReady   = $urandom_range(0, 1);
        bus.randInt      = 16'($urandom);
        bus.userInput    = ($urandom_range(0, 1) == 1) ? bus.randInt : 16'($urandom);
      end
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
